// File: rtl/evb_fsm.sv
// rtl/evb_fsm.sv - evaluate-block controller: b polynomial evaluation passes over the data buffer
// Optional overflow flagging (status = 2) when EVB_OVERFLOW_DETECT_EN is defined.
module evb_fsm #(
  parameter int buffer_size = 1024,
  localparam int AW = $clog2(buffer_size)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rst_instr,
  input  logic          start_evb,
  input  logic [2:0]    A,
  input  logic [4:0]    b,
  input  logic [15:0]   x_b,
  input  logic [15:0]   c_i,
  input  logic [4:0]    N,
  input  logic [AW-1:0] rd_addr_data,
  output logic          done_evp,
  output logic          done_evb,
  output logic          en_rd_data,
  output logic          en_rd_S,
  output logic          en_rd_N,
  output logic [AW-1:0] rd_addr_data_updated,
  output logic [6:0]    rd_addr_S,
  output logic [2:0]    rd_addr_N,
  output logic [31:0]   result,
  output logic [31:0]   status
);

  typedef enum logic [2:0] {
    E_START, E_FIRST, E_EN, E_WAIT, E_DONE, E_CHECK, E_END
  } evb_state_t;

  typedef enum logic [3:0] {
    P_START, P_RD_N, P_CHECK_N, P_RD_DATA, P_SUM, P_NEXT_C, P_EXP, P_OUTPUT, P_END
  } evp_state_t;

  evb_state_t evb_state;
  evp_state_t evp_state;

  logic [2:0]  a_q;
  logic [4:0]  b_q;
  logic [4:0]  k;
  logic [4:0]  n_q;
  logic [3:0]  i;
  logic [15:0] x_q;
  logic [15:0] c_q;
  logic [31:0] pow;
  logic [31:0] acc;
  logic [31:0] acc_next;
  logic [31:0] pow_next;
  logic [6:0]  s_base;
  logic [AW-1:0] addr_next;

  assign s_base    = {4'd0, a_q} * 7'd11;
  assign addr_next = (rd_addr_data == AW'(buffer_size - 1)) ? '0 : rd_addr_data + AW'(1);

`ifdef EVB_OVERFLOW_DETECT_EN
  logic        ovf;
  logic [63:0] term_full;
  logic [63:0] pow_full;
  logic [32:0] sum_full;
  logic        ovf_sum;
  logic        ovf_pow;

  assign term_full = {32'd0, pow} * {48'd0, c_q};
  assign pow_full  = {32'd0, pow} * {48'd0, x_q};
  assign sum_full  = {1'b0, acc} + {1'b0, term_full[31:0]};
  assign ovf_sum   = (term_full[63:32] != 32'd0) || sum_full[32];
  assign ovf_pow   = pow_full[63:32] != 32'd0;
  assign acc_next  = sum_full[31:0];
  assign pow_next  = pow_full[31:0];
`else
  assign acc_next  = acc + {16'd0, c_q} * pow;
  assign pow_next  = pow * {16'd0, x_q};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evb_state            <= E_START;
      evp_state            <= P_START;
      done_evp             <= 1'b0;
      done_evb             <= 1'b0;
      en_rd_data           <= 1'b0;
      en_rd_S              <= 1'b0;
      en_rd_N              <= 1'b0;
      rd_addr_data_updated <= '0;
      rd_addr_S            <= '0;
      rd_addr_N            <= '0;
      result               <= '0;
      status               <= '0;
      a_q                  <= '0;
      b_q                  <= '0;
      k                    <= '0;
      n_q                  <= '0;
      i                    <= '0;
      x_q                  <= '0;
      c_q                  <= '0;
      pow                  <= '0;
      acc                  <= '0;
`ifdef EVB_OVERFLOW_DETECT_EN
      ovf                  <= 1'b0;
`endif
    end else if (!rst_instr) begin
      // Instruction reset aborts the block; datapath registers are reloaded before use.
      evb_state            <= E_START;
      evp_state            <= P_START;
      done_evp             <= 1'b0;
      done_evb             <= 1'b0;
      en_rd_data           <= 1'b0;
      en_rd_S              <= 1'b0;
      en_rd_N              <= 1'b0;
      rd_addr_data_updated <= '0;
      rd_addr_S            <= '0;
      rd_addr_N            <= '0;
      result               <= '0;
      status               <= '0;
    end else begin
      case (evb_state)
        E_START: begin
          if (start_evb) begin
            a_q <= A;
            b_q <= b;
            if (b == 5'd0) begin
              evb_state <= E_END;
              done_evb  <= 1'b1;
            end else begin
              evb_state <= E_FIRST;
            end
          end
        end
        E_FIRST: begin
          k         <= '0;
          evb_state <= E_WAIT;
        end
        E_EN: evb_state <= E_WAIT;
        E_WAIT: begin
          if (evp_state == P_END) begin
            evb_state <= E_DONE;
            done_evp  <= 1'b1;
          end
        end
        E_DONE: begin
          done_evp  <= 1'b0;
          k         <= k + 5'd1;
          evb_state <= E_CHECK;
        end
        E_CHECK: begin
          if (k == b_q) begin
            evb_state <= E_END;
            done_evb  <= 1'b1;
          end else begin
            evb_state <= E_EN;
          end
        end
        E_END: begin
          done_evb  <= 1'b0;
          evb_state <= E_START;
        end
        default: evb_state <= E_START;
      endcase

      // The EVP START cycle coincides with the EVB enable cycle.
      case (evp_state)
        P_START: begin
          if (evb_state == E_FIRST || evb_state == E_EN) begin
            evp_state <= P_RD_N;
            en_rd_N   <= 1'b1;
            rd_addr_N <= a_q;
          end
        end
        P_RD_N: begin
          n_q       <= N;
          en_rd_N   <= 1'b0;
          evp_state <= P_CHECK_N;
        end
        P_CHECK_N: begin
          if (n_q > 5'd10) begin
            evp_state <= P_OUTPUT;
          end else begin
            evp_state  <= P_RD_DATA;
            en_rd_data <= 1'b1;
            en_rd_S    <= 1'b1;
            rd_addr_S  <= s_base;
            i          <= '0;
          end
        end
        P_RD_DATA: begin
          x_q                  <= x_b;
          c_q                  <= c_i;
          pow                  <= 32'd1;
          acc                  <= '0;
          en_rd_data           <= 1'b0;
          en_rd_S              <= 1'b0;
          rd_addr_data_updated <= addr_next;
`ifdef EVB_OVERFLOW_DETECT_EN
          ovf                  <= 1'b0;
`endif
          evp_state            <= P_SUM;
        end
        P_SUM: begin
          acc <= acc_next;
`ifdef EVB_OVERFLOW_DETECT_EN
          if (ovf_sum) ovf <= 1'b1;
`endif
          if ({1'b0, i} == n_q) begin
            evp_state <= P_OUTPUT;
          end else begin
            evp_state <= P_NEXT_C;
            i         <= i + 4'd1;
            en_rd_S   <= 1'b1;
            rd_addr_S <= s_base + {3'd0, i} + 7'd1;
          end
        end
        P_NEXT_C: begin
          c_q       <= c_i;
          en_rd_S   <= 1'b0;
          evp_state <= P_EXP;
        end
        P_EXP: begin
          pow <= pow_next;
`ifdef EVB_OVERFLOW_DETECT_EN
          if (ovf_pow) ovf <= 1'b1;
`endif
          evp_state <= P_SUM;
        end
        P_OUTPUT: begin
          if (n_q > 5'd10) begin
            result <= '0;
            status <= 32'd1;
          end else begin
            result <= acc;
`ifdef EVB_OVERFLOW_DETECT_EN
            status <= ovf ? 32'd2 : 32'd0;
`else
            status <= 32'd0;
`endif
          end
          evp_state <= P_END;
        end
        P_END: evp_state <= P_START;
        default: evp_state <= P_START;
      endcase
    end
  end

endmodule

// File: tb/tb_evb_fsm.sv
// tb/tb_evb_fsm.sv - randomized self-checking bench for evb_fsm against a polynomial reference model
// Honours EVB_OVERFLOW_DETECT_EN for the expected overflow status.
module tb_evb_fsm;
  localparam int BS = 1024;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          rst_instr;
  logic          start_evb;
  logic [2:0]    A;
  logic [4:0]    b;
  logic [15:0]   x_b;
  logic [15:0]   c_i;
  logic [4:0]    N;
  logic [AW-1:0] rd_addr_data;
  logic          done_evp;
  logic          done_evb;
  logic          en_rd_data;
  logic          en_rd_S;
  logic          en_rd_N;
  logic [AW-1:0] rd_addr_data_updated;
  logic [6:0]    rd_addr_S;
  logic [2:0]    rd_addr_N;
  logic [31:0]   result;
  logic [31:0]   status;

  logic [15:0] smem [0:127];
  logic [4:0]  nmem [0:7];
  logic [15:0] dbuf [0:BS-1];

  int n_checks;
  int n_fail;

  always #5 clk = ~clk;

  // Memories answer only while enabled, so a mistimed enable returns junk.
  assign c_i = en_rd_S    ? smem[rd_addr_S]    : 16'hdead;
  assign N   = en_rd_N    ? nmem[rd_addr_N]    : 5'h1f;
  assign x_b = en_rd_data ? dbuf[rd_addr_data] : 16'hbeef;

  evb_fsm #(.buffer_size(BS)) dut (
    .clk(clk), .rst(rst), .rst_instr(rst_instr), .start_evb(start_evb),
    .A(A), .b(b), .x_b(x_b), .c_i(c_i), .N(N), .rd_addr_data(rd_addr_data),
    .done_evp(done_evp), .done_evb(done_evb), .en_rd_data(en_rd_data),
    .en_rd_S(en_rd_S), .en_rd_N(en_rd_N), .rd_addr_data_updated(rd_addr_data_updated),
    .rd_addr_S(rd_addr_S), .rd_addr_N(rd_addr_N), .result(result), .status(status)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Value of sum c_j * x^j mod 2^32; overflow if any true power, term or partial sum exceeds 32 bits.
  function automatic void model(input logic [2:0] a, input logic [15:0] x,
                                output logic [31:0] res, output logic [31:0] st);
    logic [63:0] wide;
    logic [63:0] term;
    logic [31:0] pw;
    logic [31:0] total;
    bit big;
    int n;
    n = int'(nmem[a]);
    res = 32'd0;
    st = 32'd1;
    if (n > 10) return;
    pw = 32'd1;
    total = 32'd0;
    big = 1'b0;
    for (int j = 0; j <= n; j++) begin
      if (j > 0) begin
        wide = 64'(pw) * 64'(x);
        if (wide[63:32] != 32'd0) big = 1'b1;
        pw = wide[31:0];
      end
      term = 64'(smem[int'(a) * 11 + j]) * 64'(pw);
      if (term[63:32] != 32'd0) big = 1'b1;
      wide = 64'(total) + 64'(term[31:0]);
      if (wide[32]) big = 1'b1;
      total = wide[31:0];
    end
    res = total;
`ifdef EVB_OVERFLOW_DETECT_EN
    st = big ? 32'd2 : 32'd0;
`else
    st = 32'd0;
`endif
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_flags"}, {27'd0, done_evp, done_evb, en_rd_data, en_rd_S, en_rd_N}, 32'd0);
    check_eq({tag, "_addr"}, {12'd0, rd_addr_data_updated, rd_addr_S, rd_addr_N}, 32'd0);
    check_eq({tag, "_result"}, result, 32'd0);
    check_eq({tag, "_status"}, status, 32'd0);
  endtask

  task automatic run_evb(input logic [2:0] a, input logic [4:0] nb, input logic [AW-1:0] ptr0);
    int cyc, n_evp, first_en_n, len, n, evb_seen;
    logic [AW-1:0] ptr;
    logic [31:0] er, es;
    n = int'(nmem[a]);
    len = (n > 10) ? 5 : 7 + 3 * n;
    ptr = ptr0;
    rd_addr_data = ptr0;
    A = a;
    b = nb;
    start_evb = 1'b1;
    cyc = 0;
    n_evp = 0;
    first_en_n = -1;
    evb_seen = 0;
    while (evb_seen == 0 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      start_evb = 1'b0;
      if (cyc == 5) begin
        start_evb = 1'b1;
        A = a + 3'd1;
        b = 5'd0;
      end
      if (en_rd_N && first_en_n < 0) first_en_n = cyc;
      if (done_evp) begin
        model(a, dbuf[ptr], er, es);
        check_eq("result", result, er);
        check_eq("status", status, es);
        check_eq("evp_cycle", cyc, 1 + len + n_evp * (len + 2));
        if (n <= 10) check_eq("addr_upd", 32'(rd_addr_data_updated), 32'((int'(ptr) + 1) % BS));
        ptr = AW'((int'(ptr) + 1) % BS);
        rd_addr_data = ptr;
        n_evp++;
      end
      if (done_evb) begin
        evb_seen = 1;
        check_eq("evb_cycle", cyc, (nb == 0) ? 1 : 1 + len + (int'(nb) - 1) * (len + 2) + 2);
      end
    end
    start_evb = 1'b0;
    check_eq("evb_seen", evb_seen, 1);
    check_eq("evp_count", n_evp, 32'(nb));
    check_eq("en_rd_N_first", first_en_n, (nb == 0) ? -1 : 2);
    @(posedge clk);
    #1;
  endtask

  task automatic run_abort(input bit use_instr);
    int dones;
    A = 3'd0;
    b = 5'd3;
    rd_addr_data = '0;
    start_evb = 1'b1;
    @(posedge clk);
    #1;
    start_evb = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    if (use_instr) begin
      rst_instr = 1'b0;
      @(posedge clk);
      #1;
      check_idle("instr_rst");
    end else begin
      rst = 1'b1;
      #1;
      check_idle("async_rst");
    end
    rst = 1'b0;
    rst_instr = 1'b1;
    dones = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      dones += int'(done_evp) + int'(done_evb);
    end
    check_eq("abort_no_done", dones, 0);
  endtask

  initial begin
    logic [2:0] ra;
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    rst_instr = 1'b1;
    start_evb = 1'b0;
    A = '0;
    b = '0;
    rd_addr_data = '0;
    for (int j = 0; j < 128; j++) smem[j] = 16'($urandom);
    for (int j = 0; j < 8; j++) nmem[j] = 5'($urandom_range(0, 10));
    for (int j = 0; j < BS; j++) dbuf[j] = 16'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    smem[0] = 16'd3; smem[1] = 16'd4; smem[2] = 16'd2; smem[3] = 16'd1;
    nmem[0] = 5'd3;
    dbuf[0] = 16'd1; dbuf[1] = 16'd2; dbuf[2] = 16'd3;
    run_evb(3'd0, 5'd3, 10'd0);
    check_eq("plan_last_result", result, 32'd60);

    nmem[3] = 5'd11;
    run_evb(3'd3, 5'd2, 10'd10);

    nmem[2] = 5'd0;
    smem[22] = 16'd7;
    run_evb(3'd2, 5'd3, 10'd100);
    check_eq("n0_result", result, 32'd7);

    run_evb(3'd5, 5'd0, 10'd0);

    nmem[1] = 5'd3;
    for (int j = 11; j < 15; j++) smem[j] = 16'hffff;
    dbuf[200] = 16'hffff;
    run_evb(3'd1, 5'd1, 10'd200);

    nmem[4] = 5'd2;
    run_evb(3'd4, 5'd2, 10'd1023);

    run_abort(1'b0);
    run_evb(3'd0, 5'd3, 10'd0);
    run_abort(1'b1);
    run_evb(3'd0, 5'd3, 10'd0);

    repeat (25) begin
      ra = 3'($urandom);
      nmem[ra] = ($urandom_range(0, 6) == 0) ? 5'($urandom_range(11, 31)) : 5'($urandom_range(0, 10));
      for (int j = 0; j < 11; j++)
        smem[int'(ra) * 11 + j] = $urandom_range(0, 1) ? 16'($urandom_range(0, 9)) : 16'($urandom);
      for (int j = 0; j < BS; j += 7)
        dbuf[j] = $urandom_range(0, 1) ? 16'($urandom_range(0, 5)) : 16'($urandom);
      run_evb(ra, 5'($urandom_range(0, 4)), 10'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
